// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding
// req/addr_ok/data_ok instruction-memory port, holds each fetched word for
// decode, and applies branch redirects (with delay slot) and flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    // instruction memory port
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    // F/D handoff
    output logic        f_valid,
    output logic [31:0] f_raw_instr,
    output logic [31:0] f_pc,
    output logic [31:0] f_pcplus4,
    output logic        f_adel,
    input  logic        stall_f,
    // redirect resolved in decode
    input  logic        br_valid,
    input  logic        is_jr,
    input  logic        is_jump,
    input  logic        branch_taken,
    input  logic [31:0] pcjr,
    input  logic [31:0] pcjump,
    input  logic [31:0] pcbranch,
    // exception flush
    input  logic        flush_f,
    input  logic [31:0] flush_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic        pend_q, pend_d;
    logic        drop_q, drop_d;
    logic        adel_q, adel_d;

    logic        aligned;
    logic        redir;
    logic        handoff;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign aligned   = (pc_q[1:0] == 2'b00);
    assign pc_plus4  = pc_q + 32'd4;
    assign redir     = br_valid & (is_jr | is_jump | branch_taken);
    assign redir_tgt = is_jr ? pcjr : (is_jump ? pcjump : pcbranch);
    assign handoff   = (state_q == S_HOLD) & ~stall_f;
    // A redirect in the handoff cycle bypasses the pending register.
    assign next_pc   = redir ? redir_tgt : (pend_q ? tgt_q : pc_plus4);

    // Request only from REQ with an aligned PC and no discarded response owed.
    assign inst_req    = (state_q == S_REQ) & aligned & ~drop_q & ~reset;
    assign inst_addr   = pc_q;
    assign f_valid     = (state_q == S_HOLD);
    assign f_raw_instr = instr_q;
    assign f_pc        = pc_q;
    assign f_pcplus4   = pc_plus4;
    assign f_adel      = adel_q;

    // Next-state logic for the fetch FSM, PC, pending redirect and drop flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        adel_d  = adel_q;

        if (drop_q && inst_data_ok) begin
            drop_d = 1'b0;
        end

        if (flush_f) begin
            state_d = S_REQ;
            pc_d    = flush_pc;
            pend_d  = 1'b0;
            adel_d  = 1'b0;
            // Drop only a response that is still owed after this edge; one
            // arriving in the flush cycle itself is simply not latched.
            drop_d  = ((state_q == S_WAIT) && !inst_data_ok)
                    || (inst_req && inst_addr_ok)
                    || (drop_q && !inst_data_ok);
        end else begin
            if (redir && !handoff) begin
                pend_d = 1'b1;
                tgt_d  = redir_tgt;
            end
            case (state_q)
                S_REQ: begin
                    if (!aligned) begin
                        state_d = S_HOLD;
                        adel_d  = 1'b1;
                        instr_d = '0;
                    end else if (inst_req && inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state_d = S_HOLD;
                        instr_d = inst_rdata;
                    end
                end
                S_HOLD: begin
                    if (!stall_f) begin
                        state_d = S_REQ;
                        pc_d    = next_pc;
                        pend_d  = 1'b0;
                        adel_d  = 1'b0;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            instr_q <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            adel_q  <= adel_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: bench-side memory responder and decode driver,
// a behavioural program-counter model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        f_valid;
    logic [31:0] f_raw_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pcplus4;
    logic        f_adel;
    logic        stall_f;
    logic        br_valid;
    logic        is_jr;
    logic        is_jump;
    logic        branch_taken;
    logic [31:0] pcjr;
    logic [31:0] pcjump;
    logic [31:0] pcbranch;
    logic        flush_f;
    logic [31:0] flush_pc;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .f_valid      (f_valid),
        .f_raw_instr  (f_raw_instr),
        .f_pc         (f_pc),
        .f_pcplus4    (f_pcplus4),
        .f_adel       (f_adel),
        .stall_f      (stall_f),
        .br_valid     (br_valid),
        .is_jr        (is_jr),
        .is_jump      (is_jump),
        .branch_taken (branch_taken),
        .pcjr         (pcjr),
        .pcjump       (pcjump),
        .pcbranch     (pcbranch),
        .flush_f      (flush_f),
        .flush_pc     (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    // memory responder state
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int unsigned mem_cnt  = 0;
    int unsigned req_wait = 0;
    int unsigned fixed_addr_lat = 0;
    int unsigned data_lat = 0;
    logic        rand_lat = 1'b0;
    logic [31:0] acc_q[$];

    // behavioural model state
    logic        started = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_word = '0;
    logic        m_have = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_out = 1'b0;
    logic        m_live = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom();
        if (r == 1) return 32'hFFFF_FFFC;
        return 32'h0001_0000 + ($urandom_range(0, 255) << 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: one outstanding request, programmable accept and response delay.
    task automatic mem_drive();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom();
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = word_of(mem_addr);
                mem_busy     = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (inst_req) begin
            if (req_wait == 0) begin
                inst_addr_ok = 1'b1;
                mem_busy     = 1'b1;
                mem_addr     = inst_addr;
                mem_cnt      = rand_lat ? $urandom_range(0, 3) : data_lat;
                req_wait     = rand_lat ? $urandom_range(0, 3) : fixed_addr_lat;
                acc_q.push_back(inst_addr);
            end else begin
                req_wait--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        stall_f      = 1'b0;
        br_valid     = 1'b0;
        is_jr        = 1'b0;
        is_jump      = 1'b0;
        branch_taken = 1'b0;
        pcjr         = $urandom();
        pcjump       = $urandom();
        pcbranch     = $urandom();
        flush_f      = 1'b0;
        flush_pc     = $urandom();
        mem_drive();
        cyc++;
    endtask

    // Advance at least one cycle, until an instruction is presented.
    task automatic wait_valid(input string name);
        int unsigned n;
        n = 0;
        do begin
            step();
            n++;
        end while (!f_valid && n < 60);
        check({name, "_timeout"}, f_valid, 1'b1);
    endtask

    task automatic wait_accept_then_wait_state(input string name);
        int unsigned n0;
        int unsigned k;
        n0 = acc_q.size();
        k  = 0;
        while (acc_q.size() == n0 && k < 30) begin
            step();
            k++;
        end
        check({name, "_accept"}, acc_q.size(), n0 + 1);
        step();
    endtask

    // Compare process: checks outputs just before each rising edge, then
    // advances the model by the events of that edge.
    always begin : compare
        logic        exp_req;
        logic        accept;
        logic        got;
        logic        redir;
        logic        old_have;
        logic [31:0] old_pc;
        logic [31:0] tgt;
        @(negedge clk);
        #4;
        if (started && !reset) begin
            check("f_valid", f_valid, m_have);
            if (m_have) begin
                check("f_pc", f_pc, m_pc);
                check("f_pcplus4", f_pcplus4, m_pc + 32'd4);
                check("f_adel", f_adel, m_pc[1:0] != 2'b00);
                check("f_raw_instr", f_raw_instr, m_word);
            end
            exp_req = !m_have && (m_pc[1:0] == 2'b00) && !m_out;
            check("inst_req", inst_req, exp_req);
            if (exp_req) check("inst_addr", inst_addr, m_pc);
        end
        if (reset) begin
            started = 1'b1;
            m_pc    = RST_PC;
            m_have  = 1'b0;
            m_pend  = 1'b0;
            m_out   = 1'b0;
            m_live  = 1'b0;
            m_word  = '0;
        end else if (started) begin
            accept   = inst_req && inst_addr_ok;
            got      = inst_data_ok && m_out && m_live;
            if (inst_data_ok) m_out = 1'b0;
            old_have = m_have;
            old_pc   = m_pc;
            if (flush_f) begin
                m_pc   = flush_pc;
                m_have = 1'b0;
                m_pend = 1'b0;
                m_live = 1'b0;
                if (accept) m_out = 1'b1;
            end else begin
                redir = br_valid && (is_jr || is_jump || branch_taken);
                tgt   = is_jr ? pcjr : (is_jump ? pcjump : pcbranch);
                if (accept) begin
                    m_out  = 1'b1;
                    m_live = 1'b1;
                end
                if (old_have && !stall_f) begin
                    m_pc   = redir ? tgt : (m_pend ? m_tgt : m_pc + 32'd4);
                    m_pend = 1'b0;
                    m_have = 1'b0;
                end else if (redir) begin
                    m_pend = 1'b1;
                    m_tgt  = tgt;
                end
                if (got) begin
                    m_have = 1'b1;
                    m_word = inst_rdata;
                end else if (!old_have && old_pc[1:0] != 2'b00) begin
                    m_have = 1'b1;
                    m_word = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        int unsigned c[3];
        int unsigned n;
        int unsigned handoffs;
        reset        = 1'b1;
        stall_f      = 1'b0;
        br_valid     = 1'b0;
        is_jr        = 1'b0;
        is_jump      = 1'b0;
        branch_taken = 1'b0;
        pcjr         = '0;
        pcjump       = '0;
        pcbranch     = '0;
        flush_f      = 1'b0;
        flush_pc     = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;

        // reset values
        step(); step(); step();
        check("rst_f_valid", f_valid, 1'b0);
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_f_pc", f_pc, 32'hBFC0_0000);
        check("rst_f_raw_instr", f_raw_instr, 32'h0);
        check("rst_f_adel", f_adel, 1'b0);
        reset = 1'b0;

        // zero-wait sequential fetch
        for (int k = 0; k < 3; k++) begin
            wait_valid("t1");
            c[k] = cyc;
            check("t1_f_pc", f_pc, 32'hBFC0_0000 + 32'(4 * k));
            check("t1_f_pcplus4", f_pcplus4, 32'hBFC0_0004 + 32'(4 * k));
        end
        check("t1_period_a", c[1] - c[0], 3);
        check("t1_period_b", c[2] - c[1], 3);
        check("t1_addr0", acc_q[0], 32'hBFC0_0000);
        check("t1_addr1", acc_q[1], 32'hBFC0_0004);
        check("t1_addr2", acc_q[2], 32'hBFC0_0008);

        // stall in HOLD for 5 cycles
        wait_valid("t2");
        stall_f = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) stall_f = 1'b1;
            check("t2_f_pc", f_pc, 32'hBFC0_000C);
            check("t2_f_valid", f_valid, 1'b1);
            check("t2_no_req", inst_req, 1'b0);
        end
        step();
        check("t2_released", f_valid, 1'b0);
        check("t2_next_addr", inst_addr, 32'hBFC0_0010);

        // branch with the delay slot in WAIT
        wait_valid("t3_pre");
        flush_f  = 1'b1;
        flush_pc = 32'h0000_0100;
        acc_q.delete();
        wait_valid("t3_a");
        step();
        step();
        check("t3_in_wait", f_valid, 1'b0);
        br_valid     = 1'b1;
        branch_taken = 1'b1;
        pcbranch     = 32'h0000_0200;
        wait_valid("t3_b");
        check("t3_delay_slot", f_pc, 32'h0000_0104);
        wait_valid("t3_c");
        check("t3_target", f_pc, 32'h0000_0200);
        check("t3_acc2", acc_q[2], 32'h0000_0200);

        // branch in the handoff cycle (bypass)
        flush_f  = 1'b1;
        flush_pc = 32'h0000_0100;
        acc_q.delete();
        wait_valid("t3_d");
        wait_valid("t3_e");
        check("t3_bypass_slot", f_pc, 32'h0000_0104);
        br_valid     = 1'b1;
        branch_taken = 1'b1;
        pcbranch     = 32'h0000_0200;
        wait_valid("t3_f");
        check("t3_bypass_target", f_pc, 32'h0000_0200);
        check("t3_bypass_acc2", acc_q[2], 32'h0000_0200);
        // jump has priority over a taken branch
        br_valid     = 1'b1;
        is_jump      = 1'b1;
        branch_taken = 1'b1;
        pcjump       = 32'h0000_0300;
        pcbranch     = 32'h0000_0400;
        wait_valid("t3_g");
        check("t3_jump_prio", f_pc, 32'h0000_0300);

        // flush while a response is outstanding
        data_lat = 3;
        wait_accept_then_wait_state("t4");
        check("t4_in_wait", inst_req, 1'b0);
        flush_f  = 1'b1;
        flush_pc = 32'hBFC0_0380;
        n = acc_q.size();
        data_lat = 0;
        wait_valid("t4");
        check("t4_f_pc", f_pc, 32'hBFC0_0380);
        check("t4_acc", acc_q[n], 32'hBFC0_0380);

        // jr to misaligned address; jr wins over jump
        br_valid = 1'b1;
        is_jr    = 1'b1;
        is_jump  = 1'b1;
        pcjr     = 32'h0000_1002;
        pcjump   = 32'h0000_5000;
        n = acc_q.size();
        wait_valid("t5");
        check("t5_f_adel", f_adel, 1'b1);
        check("t5_f_pc", f_pc, 32'h0000_1002);
        check("t5_f_raw_instr", f_raw_instr, 32'h0);
        check("t5_f_pcplus4", f_pcplus4, 32'h0000_1006);
        check("t5_no_request", acc_q.size(), n);

        // delayed acceptance, then flush before acceptance
        stall_f        = 1'b1;
        flush_f        = 1'b1;
        flush_pc       = 32'h0000_2000;
        fixed_addr_lat = 4;
        req_wait       = 4;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_req_held", inst_req, 1'b1);
            check("t6_addr_held", inst_addr, 32'h0000_2000);
        end
        wait_valid("t6_a");
        check("t6_f_pc", f_pc, 32'h0000_2000);
        step();
        step();
        flush_f  = 1'b1;
        flush_pc = 32'h0000_3000;
        step();
        check("t6_withdraw_req", inst_req, 1'b1);
        check("t6_withdraw_addr", inst_addr, 32'h0000_3000);
        fixed_addr_lat = 0;
        req_wait       = 0;
        wait_valid("t6_b");
        check("t6_flush_pc", f_pc, 32'h0000_3000);

        // pc+4 wraps to zero
        flush_f  = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        wait_valid("wrap_a");
        check("wrap_f_pc", f_pc, 32'hFFFF_FFFC);
        check("wrap_f_pcplus4", f_pcplus4, 32'h0);
        wait_valid("wrap_b");
        check("wrap_next", f_pc, 32'h0);

        // reset mid-transaction with a late response
        data_lat = 3;
        wait_accept_then_wait_state("rst_mid");
        reset = 1'b1;
        step();
        step();
        reset    = 1'b0;
        data_lat = 0;
        wait_valid("rst_mid");
        check("rst_mid_f_pc", f_pc, 32'hBFC0_0000);
        check("rst_mid_word", f_raw_instr, word_of(32'hBFC0_0000));

        // randomized traffic against the model
        rand_lat = 1'b1;
        handoffs = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            stall_f = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) begin
                br_valid     = 1'b1;
                is_jr        = ($urandom_range(0, 3) == 0);
                is_jump      = ($urandom_range(0, 3) == 0);
                branch_taken = $urandom_range(0, 1) == 1;
                pcjr         = rand_addr();
                pcjump       = rand_addr();
                pcbranch     = rand_addr();
            end
            if ($urandom_range(0, 39) == 0) begin
                flush_f  = 1'b1;
                flush_pc = rand_addr();
            end
            if (f_valid && !stall_f && !flush_f) handoffs++;
        end
        check("random_progress", handoffs >= 200, 1'b1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of decode.
- Owns the PC register and drives a single-outstanding req/addr_ok/data_ok instruction-memory port.
- Buffers each returned word and presents it to the F/D pipeline register.
- Applies the redirect decode resolves for a branch/jump (MIPS delay-slot semantics) and exception flushes.

Parameters:
RESET_PC, 32'hBFC0_0000, PC after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
inst_req  out  1  imem request
inst_addr  out  32  request address (= pc)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response valid this cycle
inst_rdata  in  32  response word
f_valid  out  1  fetched instruction available to decode
f_raw_instr  out  32  instruction word (0 when f_adel)
f_pc  out  32  its address
f_pcplus4  out  32  f_pc + 4
f_adel  out  1  misaligned fetch address
stall_f  in  1  decode not accepting; handoff = f_valid & ~stall_f
br_valid  in  1  branch/jump leaves decode this cycle
is_jr  in  1  decode: register jump
is_jump  in  1  decode: direct jump
branch_taken  in  1  decode: conditional branch taken
pcjr  in  32  jr target
pcjump  in  32  j/jal target
pcbranch  in  32  branch target
flush_f  in  1  discard fetch state, restart at flush_pc
flush_pc  in  32  restart address

Behaviour:
- Reset: pc=RESET_PC, state=REQ, f_valid=0, f_adel=0, inst_req=0, f_raw_instr=0, pend=0, drop=0.
  - inst_req may first assert in the cycle after reset deasserts.
- State REQ, pc aligned:
  - inst_req=1, inst_addr=pc.
  - On inst_addr_ok, go to WAIT.
- State REQ, pc[1:0]!=0:
  - No request issued.
  - Next state HOLD with f_adel=1, f_raw_instr=0.
- State WAIT: on inst_data_ok, latch inst_rdata and go to HOLD.
- State HOLD:
  - f_valid=1; outputs are stable while stall_f=1.
  - On handoff: pc<=next_pc, pend<=0, f_valid<=0, state<=REQ.
- Minimum throughput is 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory.
- Redirect:
  - redir = br_valid & (is_jr | is_jump | branch_taken).
  - Target priority: is_jr→pcjr, else is_jump→pcjump, else pcbranch.
  - If redir occurs without a same-cycle handoff, latch pend=1 and tgt.
  - next_pc = redir ? target (same-cycle bypass) : pend ? tgt : pc+4.
  - The instruction in F when the branch leaves D is the delay slot. It is always delivered; the target follows it.
- Flush (priority over everything except reset):
  - pc<=flush_pc, f_valid<=0, f_adel<=0, pend<=0, state<=REQ.
  - If a request is outstanding (state WAIT, or REQ with inst_addr_ok this cycle), set drop=1.
  - While drop=1, inst_req=0. The next inst_data_ok is discarded and clears drop; requesting resumes the following cycle.
  - A not-yet-accepted request is withdrawn. inst_addr may change while inst_addr_ok has not been seen.
- Simultaneous events:
  - flush_f with br_valid: the redirect is ignored.
  - br_valid while f_valid=0: the redirect is latched and applied at the next handoff.
  - inst_data_ok while drop=0 and state≠WAIT: protocol error; ignored.
- Arithmetic: pc+4 is modulo 2^32 (wraps from 0xFFFF_FFFC to 0).
- Reset mid-transaction: all state returns to its reset values. A late inst_data_ok after reset is ignored.

Test Plan:
1. Reset, then 1-cycle addr_ok/data_ok memory → addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 issued; f_valid every 3rd cycle with matching f_pc and f_pcplus4.
2. Hold stall_f=1 for 5 cycles in HOLD → f_raw_instr/f_pc unchanged, no new inst_req; one handoff on release.
3. Branch at 0x100 leaves D with branch_taken=1, pcbranch=0x200, while 0x104 is in WAIT → 0x104 delivered, next request at 0x200. Repeat with same-cycle handoff (bypass path) → next request also at 0x200.
4. flush_f with flush_pc=0xBFC00380 while in WAIT → no inst_req until data_ok arrives; that word is not presented; next request at 0xBFC00380.
5. br_valid with is_jr=1, pcjr=0x1002 → no request to 0x1002; f_valid=1, f_adel=1, f_pc=0x1002, f_raw_instr=0.
6. inst_addr_ok delayed 4 cycles → inst_req and inst_addr held constant throughout. Apply flush_f before acceptance → inst_addr becomes flush_pc next cycle and drop stays 0.
